bankgroup_access_ctrl: RTL and testbench

Request-side controller for a BankGroup. It accepts single burst requests (read or write, target bank, row, start column) over a valid/ready handshake. It then drives the BankGroup's per-bank `rd_o_wr`, `dqin`, `row` and `column` arrays for BL consecutive columns, and returns read beats captured from the per-bank `dqout` array. It sits between the channel/rank scheduler and one BankGroup instance, and shares that instance's clock.

---
 rtl/bankgroup_pkg.sv | 25 ++
 rtl/bankgroup_access_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_bankgroup_access_ctrl.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bankgroup_pkg.sv
// -----------------------------------------------------------------------------
// bankgroup_pkg
//
// Definitions shared by the BankGroup request controller and the Bank /
// BankGroup benches:
//   bg_state_e     - controller FSM states
//   BG_DEFAULT_BL  - default burst length in beats
//   BG_RD / BG_WR  - encoding of the per-bank rd_o_wr strobe
// -----------------------------------------------------------------------------
package bankgroup_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } bg_state_e;

    localparam int BG_DEFAULT_BL = 8;

    // A read is the harmless resting value of rd_o_wr.
    localparam logic BG_RD = 1'b0;
    localparam logic BG_WR = 1'b1;

endpackage

// File: rtl/bankgroup_access_ctrl.sv
// -----------------------------------------------------------------------------
// bankgroup_access_ctrl
//
// Request-side controller for one BankGroup. Accepts a single read or write
// burst over a valid/ready handshake, walks BL consecutive columns on the
// selected bank's ports and returns read beats captured from that bank.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req_valid/ready   request handshake
//   req_wr            1 = write burst, 0 = read burst
//   req_bank/row/col  target bank, row and start column
//   wr_data/wr_ready  write beat, consumed in every WRITE cycle
//   rd_data/valid     registered read beat, one pulse per beat
//   rd_last           flags the final read beat
//   busy              burst in progress
//   rd_o_wr, dqin,
//   row, column       per-bank command/data outputs to the BankGroup
//   dqout             per-bank read data from the BankGroup
// -----------------------------------------------------------------------------
module bankgroup_access_ctrl
    import bankgroup_pkg::*;
#(
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int CHWIDTH      = 5,
    parameter int BL           = BG_DEFAULT_BL
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [BAWIDTH-1:0]      req_bank,
    input  logic [CHWIDTH-1:0]      req_row,
    input  logic [COLWIDTH-1:0]     req_col,

    input  logic [DEVICE_WIDTH-1:0] wr_data,
    output logic                    wr_ready,

    output logic [DEVICE_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,

    output logic                    busy,

    output logic [0:0]              rd_o_wr [0:(2**BAWIDTH)-1],
    output logic [DEVICE_WIDTH-1:0] dqin    [0:(2**BAWIDTH)-1],
    input  logic [DEVICE_WIDTH-1:0] dqout   [0:(2**BAWIDTH)-1],
    output logic [CHWIDTH-1:0]      row     [0:(2**BAWIDTH)-1],
    output logic [COLWIDTH-1:0]     column  [0:(2**BAWIDTH)-1]
);

    localparam int BANKSPERGROUP = 2**BAWIDTH;
    localparam int CNTW          = $clog2(BL);

    bg_state_e             state_q;
    bg_state_e             state_d;

    logic [BAWIDTH-1:0]    lat_bank;
    logic [CHWIDTH-1:0]    lat_row;
    logic [COLWIDTH-1:0]   lat_col;
    logic                  lat_wr;

    // Index of the beat currently presented on the bank ports.
    logic [CNTW-1:0]       beat_q;
    logic [CNTW-1:0]       next_beat;
    logic                  last_beat;

    // Held low through reset and set on the first edge afterwards, so that
    // a request waiting across reset is not taken in the release cycle.
    logic                  ready_en_q;

    logic                  handshake;
    logic                  in_burst;

    logic                  drv_en;
    logic                  drv_wr;
    logic [BAWIDTH-1:0]    drv_bank;
    logic [CHWIDTH-1:0]    drv_row;
    logic [COLWIDTH-1:0]   drv_col;

    assign req_ready = ready_en_q && (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign handshake = req_valid && req_ready;
    assign in_burst  = (state_q == WRITE) || (state_q == READ);
    assign next_beat = beat_q + CNTW'(1);
    assign last_beat = (beat_q == CNTW'(BL - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a write returns straight to IDLE after its last beat,
    // a read spends one DRAIN cycle so the final dqout can be captured.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (handshake) state_d = req_wr ? WRITE : READ;
            WRITE:   if (last_beat) state_d = IDLE;
            READ:    if (last_beat) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_bank   <= '0;
            lat_row    <= '0;
            lat_col    <= '0;
            lat_wr     <= BG_RD;
            beat_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (handshake) begin
                lat_bank <= req_bank;
                lat_row  <= req_row;
                lat_col  <= req_col;
                lat_wr   <= req_wr;
                beat_q   <= '0;
            end else if (in_burst) begin
                beat_q <= next_beat;
            end
        end
    end

    // Bank ports are registered, so this computes what they show in the next
    // cycle: beat 0 straight from the request on the accepting edge, then
    // each following beat until the last one has been presented. The column
    // sum truncates to COLWIDTH bits, which gives the modulo wrap.
    always_comb begin
        drv_en   = 1'b0;
        drv_wr   = lat_wr;
        drv_bank = lat_bank;
        drv_row  = lat_row;
        drv_col  = lat_col + COLWIDTH'(next_beat);
        if (handshake) begin
            drv_en   = 1'b1;
            drv_wr   = req_wr;
            drv_bank = req_bank;
            drv_row  = req_row;
            drv_col  = req_col;
        end else if (in_burst && !last_beat) begin
            drv_en = 1'b1;
        end
    end

    // Per-bank command registers; unselected banks rest at read, row 0,
    // column 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANKSPERGROUP; b++) begin
                rd_o_wr[b] <= BG_RD;
                row[b]     <= '0;
                column[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < BANKSPERGROUP; b++) begin
                if (drv_en && (drv_bank == BAWIDTH'(b))) begin
                    rd_o_wr[b] <= drv_wr;
                    row[b]     <= drv_row;
                    column[b]  <= drv_col;
                end else begin
                    rd_o_wr[b] <= BG_RD;
                    row[b]     <= '0;
                    column[b]  <= '0;
                end
            end
        end
    end

    // Write data has no back-pressure and is passed straight through in the
    // same cycle as the registered column it belongs to, so it is the one
    // combinational bank-side output.
    always_comb begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
            dqin[b] = '0;
            if ((state_q == WRITE) && (lat_bank == BAWIDTH'(b))) begin
                dqin[b] = wr_data;
            end
        end
    end

    // Read return: each READ cycle captures the addressed bank's data, so the
    // beat shows up one cycle after it was driven. The last capture happens
    // on the edge leaving READ, which is why DRAIN exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (state_q == READ) begin
            rd_data  <= dqout[lat_bank];
            rd_valid <= 1'b1;
            rd_last  <= last_beat;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bankgroup_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bankgroup_access_ctrl
//
// Drives bursts into bankgroup_access_ctrl with a simple behavioural BankGroup
// attached (writes on the clock edge, combinational read), and checks the
// bank-side activity and returned read data against an independent memory
// model holding what each burst was meant to store.
// -----------------------------------------------------------------------------
module tb_bankgroup_access_ctrl;
    import bankgroup_pkg::*;

    localparam int BAW  = 2;
    localparam int COLW = 10;
    localparam int DW   = 4;
    localparam int CHW  = 5;
    localparam int BL   = 8;
    localparam int NB   = 4;
    localparam int NROW = 32;
    localparam int NCOL = 1024;
    localparam int NOBS = BL + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [BAW-1:0]  req_bank;
    logic [CHW-1:0]  req_row;
    logic [COLW-1:0] req_col;
    logic [DW-1:0]   wr_data;
    logic            wr_ready;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            rd_last;
    logic            busy;
    logic [0:0]      rd_o_wr [0:NB-1];
    logic [DW-1:0]   dqin    [0:NB-1];
    logic [DW-1:0]   dqout   [0:NB-1];
    logic [CHW-1:0]  row     [0:NB-1];
    logic [COLW-1:0] column  [0:NB-1];

    int n_checks;
    int n_fail;

    bankgroup_access_ctrl #(
        .BAWIDTH      (BAW),
        .COLWIDTH     (COLW),
        .DEVICE_WIDTH (DW),
        .CHWIDTH      (CHW),
        .BL           (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_col   (req_col),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .busy      (busy),
        .rd_o_wr   (rd_o_wr),
        .dqin      (dqin),
        .dqout     (dqout),
        .row       (row),
        .column    (column)
    );

    always #5 clk = ~clk;

    // Deterministic background contents shared by the bank and the model.
    function automatic logic [DW-1:0] init_val(input int b, input int r, input int c);
        return DW'((b * 5) + (r * 3) + c + (c >> 3));
    endfunction

    function automatic int mcol(input int cl, input int k);
        return (cl + k) % NCOL;
    endfunction

    // Behavioural BankGroup.
    logic [DW-1:0] bmem [NB][NROW][NCOL];

    initial begin
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NROW; r++)
                for (int c = 0; c < NCOL; c++)
                    bmem[b][r][c] = init_val(b, r, c);
        forever begin
            @(posedge clk);
            for (int b = 0; b < NB; b++)
                if (rd_o_wr[b] === 1'b1)
                    bmem[b][row[b]][column[b]] <= dqin[b];
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++)
            dqout[b] = bmem[b][row[b]][column[b]];
    end

    // Reference model of intended memory contents.
    logic [DW-1:0] rmem [NB][NROW][NCOL];
    logic [DW-1:0] wbuf [BL];

    task automatic model_write(input int b, input int r, input int cl);
        for (int k = 0; k < BL; k++)
            rmem[b][r][mcol(cl, k)] = wbuf[k];
    endtask

    // Per-cycle observations of one burst; index = cycles after the
    // accepting edge.
    logic [NB-1:0]   o_wen  [NOBS];
    logic [COLW-1:0] o_col  [NOBS][NB];
    logic [CHW-1:0]  o_row  [NOBS][NB];
    logic [DW-1:0]   o_dqin [NOBS][NB];
    logic            o_rdv  [NOBS];
    logic            o_rdl  [NOBS];
    logic [DW-1:0]   o_rdd  [NOBS];
    logic            o_rdy  [NOBS];
    logic            o_busy [NOBS];
    logic            o_wrr  [NOBS];
    int              hs2;

    // Requests one burst (entered in the low clock phase), supplies write
    // beats while wr_ready is high and records every cycle. With nxt_en the
    // next request is presented from cycle 1 and recording stops in the
    // cycle req_ready returns, leaving that handshake for the next call.
    task automatic drive_burst(input logic wr, input int bank, input int rw, input int cl,
                               input logic nxt_en, input logic nxt_wr, input int nxt_bank,
                               input int nxt_row, input int nxt_col);
        int wait_cnt;
        int beat;
        for (int c = 0; c < NOBS; c++) begin
            o_wen[c] = 'x; o_rdv[c] = 1'bx; o_rdl[c] = 1'bx; o_rdd[c] = 'x;
            o_rdy[c] = 1'bx; o_busy[c] = 1'bx; o_wrr[c] = 1'bx;
            for (int b = 0; b < NB; b++) begin
                o_col[c][b] = 'x; o_row[c][b] = 'x; o_dqin[c][b] = 'x;
            end
        end
        hs2       = 0;
        req_wr    = wr;
        req_bank  = BAW'(bank);
        req_row   = CHW'(rw);
        req_col   = COLW'(cl);
        req_valid = 1'b1;
        #1;
        wait_cnt = 0;
        while (req_ready !== 1'b1 && wait_cnt < 40) begin
            @(negedge clk); #1;
            wait_cnt++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL handshake_timeout: req_ready=%b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        beat = 0;
        for (int c = 1; c < NOBS; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (nxt_en) begin
                    req_wr   = nxt_wr;
                    req_bank = BAW'(nxt_bank);
                    req_row  = CHW'(nxt_row);
                    req_col  = COLW'(nxt_col);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (wr_ready === 1'b1 && beat < BL) begin
                wr_data = wbuf[beat];
                beat++;
            end
            #1;
            o_rdv[c] = rd_valid; o_rdl[c] = rd_last; o_rdd[c] = rd_data;
            o_rdy[c] = req_ready; o_busy[c] = busy; o_wrr[c] = wr_ready;
            for (int b = 0; b < NB; b++) begin
                o_wen[c][b]  = rd_o_wr[b][0];
                o_col[c][b]  = column[b];
                o_row[c][b]  = row[b];
                o_dqin[c][b] = dqin[b];
            end
            if (nxt_en && req_ready === 1'b1) begin
                hs2 = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_bank = 2'd1;
        req_row = '0; req_col = '0;
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++;
            if (req_ready !== 1'b0 || wr_ready !== 1'b0 || busy !== 1'b0 ||
                rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_ctrl: rdy=%b wrr=%b busy=%b rdv=%b rdl=%b rdd=%h, required all 0",
                         req_ready, wr_ready, busy, rd_valid, rd_last, rd_data);
            end
            for (int b = 0; b < NB; b++) begin
                n_checks++;
                if (rd_o_wr[b] !== 1'b0 || row[b] !== '0 || column[b] !== '0 || dqin[b] !== '0) begin
                    n_fail++;
                    $display("[TB] FAIL reset_bank%0d: rd_o_wr=%b row=%h col=%h dqin=%h, required 0",
                             b, rd_o_wr[b], row[b], column[b], dqin[b]);
                end
            end
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: req_ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        drive_burst(1'b0, 1, 0, 0, 1'b0, 1'b0, 0, 0, 0);
        n_checks++;
        if (o_busy[1] !== 1'b1 || o_rdl[BL+1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL release_burst: busy@1=%b rd_last@%0d=%b, required 1 1",
                     o_busy[1], BL + 1, o_rdl[BL+1]);
        end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < BL; k++) wbuf[k] = DW'(k + 1);
        drive_burst(1'b1, 2, 5, 'h010, 1'b0, 1'b0, 0, 0, 0);
        model_write(2, 5, 'h010);
        for (int c = 1; c <= BL; c++) begin
            n_checks++;
            if (o_wen[c] !== 4'b0100 || o_wrr[c] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL wr_strobe c%0d: rd_o_wr=%b wr_ready=%b, required 0100 1",
                         c, o_wen[c], o_wrr[c]);
            end
            n_checks++;
            if (o_col[c][2] !== COLW'(mcol('h010, c - 1)) || o_row[c][2] !== CHW'(5) ||
                o_dqin[c][2] !== wbuf[c-1]) begin
                n_fail++;
                $display("[TB] FAIL wr_beat c%0d: col=%h row=%h dqin=%h, required %h 05 %h",
                         c, o_col[c][2], o_row[c][2], o_dqin[c][2], mcol('h010, c - 1), wbuf[c-1]);
            end
            n_checks++;
            if (o_col[c][0] !== '0 || o_row[c][1] !== '0 || o_dqin[c][3] !== '0) begin
                n_fail++;
                $display("[TB] FAIL wr_idle_banks c%0d: col0=%h row1=%h dqin3=%h, required 0",
                         c, o_col[c][0], o_row[c][1], o_dqin[c][3]);
            end
        end
        n_checks++;
        if (o_wen[BL+1] !== '0 || o_busy[BL+1] !== 1'b0 || o_rdy[BL+1] !== 1'b1 || o_wrr[BL+1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wr_end: rd_o_wr=%b busy=%b rdy=%b wrr=%b, required 0000 0 1 0",
                     o_wen[BL+1], o_busy[BL+1], o_rdy[BL+1], o_wrr[BL+1]);
        end

        drive_burst(1'b0, 2, 5, 'h010, 1'b0, 1'b0, 0, 0, 0);
        for (int c = 1; c <= BL + 2; c++) begin
            n_checks++;
            if (o_rdv[c] !== (c >= 2 && c <= BL + 1) || o_rdl[c] !== (c == BL + 1)) begin
                n_fail++;
                $display("[TB] FAIL rd_flags c%0d: rd_valid=%b rd_last=%b, required %b %b",
                         c, o_rdv[c], o_rdl[c], (c >= 2 && c <= BL + 1), (c == BL + 1));
            end
            if (c >= 2 && c <= BL + 1) begin
                n_checks++;
                if (o_rdd[c] !== rmem[2][5][mcol('h010, c - 2)]) begin
                    n_fail++;
                    $display("[TB] FAIL rd_data c%0d: got %h, required %h",
                             c, o_rdd[c], rmem[2][5][mcol('h010, c - 2)]);
                end
            end
            if (c <= BL) begin
                n_checks++;
                if (o_wen[c] !== '0 || o_col[c][2] !== COLW'(mcol('h010, c - 1))) begin
                    n_fail++;
                    $display("[TB] FAIL rd_addr c%0d: rd_o_wr=%b col=%h, required 0000 %h",
                             c, o_wen[c], o_col[c][2], mcol('h010, c - 1));
                end
            end
        end
        n_checks++;
        if (o_rdy[BL+1] !== 1'b0 || o_rdy[BL+2] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rd_ready_return: rdy@%0d=%b rdy@%0d=%b, required 0 1",
                     BL + 1, o_rdy[BL+1], BL + 2, o_rdy[BL+2]);
        end
    endtask

    task automatic test_column_wrap();
        for (int k = 0; k < BL; k++) wbuf[k] = DW'(BL - k);
        drive_burst(1'b1, 1, 7, 'h3FC, 1'b0, 1'b0, 0, 0, 0);
        model_write(1, 7, 'h3FC);
        for (int c = 1; c <= BL; c++) begin
            n_checks++;
            if (o_wen[c] !== 4'b0010 || o_col[c][1] !== COLW'(mcol('h3FC, c - 1))) begin
                n_fail++;
                $display("[TB] FAIL wrap_col c%0d: rd_o_wr=%b col=%h, required 0010 %h",
                         c, o_wen[c], o_col[c][1], mcol('h3FC, c - 1));
            end
        end
        drive_burst(1'b0, 1, 7, 'h3FC, 1'b0, 1'b0, 0, 0, 0);
        for (int c = 2; c <= BL + 1; c++) begin
            n_checks++;
            if (o_rdv[c] !== 1'b1 || o_rdd[c] !== DW'(BL - (c - 2))) begin
                n_fail++;
                $display("[TB] FAIL wrap_rd c%0d: rd_valid=%b rd_data=%h, required 1 %h",
                         c, o_rdv[c], o_rdd[c], DW'(BL - (c - 2)));
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_burst(1'b0, 0, 3, 'h100, 1'b1, 1'b1, 0, 3, 'h108);
        n_checks++;
        if (hs2 !== BL + 2 || o_rdl[BL+1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_read: req_ready back in cycle %0d rd_last=%b, required %0d 1",
                     hs2, o_rdl[BL+1], BL + 2);
        end
        for (int k = 0; k < BL; k++) wbuf[k] = DW'($urandom);
        drive_burst(1'b1, 0, 3, 'h108, 1'b1, 1'b1, 3, 4, 'h050);
        model_write(0, 3, 'h108);
        n_checks++;
        if (hs2 !== BL + 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_write: req_ready back in cycle %0d, required %0d", hs2, BL + 1);
        end
        for (int k = 0; k < BL; k++) wbuf[k] = DW'($urandom);
        drive_burst(1'b1, 3, 4, 'h050, 1'b0, 1'b0, 0, 0, 0);
        model_write(3, 4, 'h050);
        for (int c = 1; c <= BL; c++) begin
            n_checks++;
            if (o_wen[c] !== 4'b1000 || o_dqin[c][3] !== wbuf[c-1]) begin
                n_fail++;
                $display("[TB] FAIL b2b_second_wr c%0d: rd_o_wr=%b dqin=%h, required 1000 %h",
                         c, o_wen[c], o_dqin[c][3], wbuf[c-1]);
            end
        end
        drive_burst(1'b0, 0, 3, 'h108, 1'b0, 1'b0, 0, 0, 0);
        for (int c = 2; c <= BL + 1; c++) begin
            n_checks++;
            if (o_rdd[c] !== rmem[0][3][mcol('h108, c - 2)]) begin
                n_fail++;
                $display("[TB] FAIL b2b_readback c%0d: got %h, required %h",
                         c, o_rdd[c], rmem[0][3][mcol('h108, c - 2)]);
            end
        end
    endtask

    task automatic test_bank_isolation();
        int order [4] = '{0, 3, 1, 2};
        for (int k = 0; k < BL; k++) wbuf[k] = 4'hF;
        drive_burst(1'b1, 0, 9, 'h200, 1'b0, 1'b0, 0, 0, 0);
        model_write(0, 9, 'h200);
        for (int k = 0; k < BL; k++) wbuf[k] = 4'h0;
        drive_burst(1'b1, 3, 9, 'h200, 1'b0, 1'b0, 0, 0, 0);
        model_write(3, 9, 'h200);
        for (int i = 0; i < 4; i++) begin
            drive_burst(1'b0, order[i], 9, 'h200, 1'b0, 1'b0, 0, 0, 0);
            for (int c = 2; c <= BL + 1; c++) begin
                n_checks++;
                if (o_rdv[c] !== 1'b1 || o_rdd[c] !== rmem[order[i]][9][mcol('h200, c - 2)]) begin
                    n_fail++;
                    $display("[TB] FAIL iso_bank%0d c%0d: rd_valid=%b rd_data=%h, required 1 %h",
                             order[i], c, o_rdv[c], o_rdd[c], rmem[order[i]][9][mcol('h200, c - 2)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int wait_cnt;
        req_wr = 1'b0; req_bank = 2'd2; req_row = CHW'(5); req_col = COLW'('h010);
        req_valid = 1'b1;
        #1;
        wait_cnt = 0;
        while (req_ready !== 1'b1 && wait_cnt < 40) begin
            @(negedge clk); #1;
            wait_cnt++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_handshake: req_ready=%b, required 1", req_ready);
        end
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== rmem[2][5][mcol('h010, 3)]) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_beat3: rd_valid=%b rd_data=%h, required 1 %h",
                     rd_valid, rd_data, rmem[2][5][mcol('h010, 3)]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 ||
            rd_o_wr[2] !== 1'b0 || column[2] !== '0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_now: rdv=%b rdl=%b busy=%b rdy=%b col2=%h, required 0",
                     rd_valid, rd_last, busy, req_ready, column[2]);
        end
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_hold: rd_valid=%b rd_last=%b, required 0 0",
                         rd_valid, rd_last);
            end
        end
        rst = 1'b0;
        @(negedge clk); #1;
        drive_burst(1'b0, 2, 5, 'h010, 1'b0, 1'b0, 0, 0, 0);
        for (int c = 2; c <= BL + 1; c++) begin
            n_checks++;
            if (o_rdd[c] !== rmem[2][5][mcol('h010, c - 2)] || o_rdl[c] !== (c == BL + 1)) begin
                n_fail++;
                $display("[TB] FAIL post_reset_rd c%0d: rd_data=%h rd_last=%b, required %h %b",
                         c, o_rdd[c], o_rdl[c], rmem[2][5][mcol('h010, c - 2)], (c == BL + 1));
            end
        end
    endtask

    task automatic test_random();
        int b, r, cl, lb, lr, lc;
        logic wr, have_wr;
        logic [NB-1:0] mask;
        have_wr = 1'b0; lb = 0; lr = 0; lc = 0;
        repeat (24) begin
            wr = 1'($urandom_range(0, 1));
            b  = $urandom_range(0, NB - 1);
            r  = $urandom_range(0, NROW - 1);
            cl = ($urandom_range(0, 3) == 0) ? NCOL - $urandom_range(1, BL) : $urandom_range(0, NCOL - 1);
            if (!wr && have_wr && $urandom_range(0, 1) == 1) begin
                b = lb; r = lr; cl = lc;
            end
            mask = NB'(1) << b;
            if (wr) begin
                for (int k = 0; k < BL; k++) wbuf[k] = DW'($urandom);
                drive_burst(1'b1, b, r, cl, 1'b0, 1'b0, 0, 0, 0);
                model_write(b, r, cl);
                have_wr = 1'b1; lb = b; lr = r; lc = cl;
                for (int c = 1; c <= BL; c++) begin
                    n_checks++;
                    if (o_wen[c] !== mask || o_col[c][b] !== COLW'(mcol(cl, c - 1)) ||
                        o_dqin[c][b] !== wbuf[c-1]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_wr b%0d c%0d: rd_o_wr=%b col=%h dqin=%h, required %b %h %h",
                                 b, c, o_wen[c], o_col[c][b], o_dqin[c][b], mask, mcol(cl, c - 1), wbuf[c-1]);
                    end
                end
            end else begin
                drive_burst(1'b0, b, r, cl, 1'b0, 1'b0, 0, 0, 0);
                for (int c = 2; c <= BL + 1; c++) begin
                    n_checks++;
                    if (o_rdv[c] !== 1'b1 || o_rdl[c] !== (c == BL + 1) ||
                        o_rdd[c] !== rmem[b][r][mcol(cl, c - 2)]) begin
                        n_fail++;
                        $display("[TB] FAIL rand_rd b%0d c%0d: rdv=%b rdl=%b rdd=%h, required 1 %b %h",
                                 b, c, o_rdv[c], o_rdl[c], o_rdd[c], (c == BL + 1), rmem[b][r][mcol(cl, c - 2)]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        wr_data   = '0;
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NROW; r++)
                for (int c = 0; c < NCOL; c++)
                    rmem[b][r][c] = init_val(b, r, c);
        test_reset();
        test_write_read();
        test_column_wrap();
        test_back_to_back();
        test_bank_isolation();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
